// File: rtl/mips32_pkg.sv
// mips32 shared definitions: opcodes, instruction classes
// and the MEM/WB bundle used by the back-end stages.
package mips32_pkg;

  localparam logic [5:0] ADD   = 6'h00;
  localparam logic [5:0] SUB   = 6'h01;
  localparam logic [5:0] AND   = 6'h02;
  localparam logic [5:0] OR    = 6'h03;
  localparam logic [5:0] SLT   = 6'h04;
  localparam logic [5:0] MUL   = 6'h05;
  localparam logic [5:0] HLT   = 6'h3f;
  localparam logic [5:0] LW    = 6'h08;
  localparam logic [5:0] SW    = 6'h09;
  localparam logic [5:0] ADDI  = 6'h0a;
  localparam logic [5:0] SUBI  = 6'h0b;
  localparam logic [5:0] SLTI  = 6'h0c;
  localparam logic [5:0] BNEQZ = 6'h0d;
  localparam logic [5:0] BEQZ  = 6'h0e;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } itype_t;

  typedef struct packed {
    logic        valid;
    itype_t      ty;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        oor;
  } mem_wb_t;

  function automatic logic is_mem(input itype_t t);
    return (t == LOAD) || (t == STORE);
  endfunction

endpackage

// File: rtl/mips32_dmem.sv
// Dual-port data memory: port A is the pipeline, port B debug.
// Port A wins a same-address write collision.
module mips32_dmem
  import mips32_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_a_en,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [31:0]   i_a_wdata,
  output logic [31:0]   o_a_rdata,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [31:0]   i_b_wdata,
  output logic [31:0]   o_b_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;
  logic        w_b_wr;

  assign w_b_wr = i_b_we &&
    !(i_a_we && (i_a_addr == i_b_addr));

  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (w_b_wr) r_mem[i_b_addr] <= i_b_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (i_a_en)
        r_a_rdata <= i_a_we ? i_a_wdata
                            : r_mem[i_a_addr];
      r_b_rdata <= r_mem[i_b_addr];
    end
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/mips32_mem_wb.sv
// mips32 back end: MEM access, register write-back
// and the sticky halt state that freezes the front end.
module mips32_mem_wb
  import mips32_pkg::*;
#(
  parameter int DMEM_WORDS = 1024,
  parameter int AW         = 10
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          ex_mem_valid,
  input  logic [31:0]   ex_mem_ir,
  input  logic [2:0]    ex_mem_type,
  input  logic [31:0]   ex_mem_aluout,
  input  logic [31:0]   ex_mem_b,
  input  logic          taken_branch,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic [31:0]   dbg_rdata,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  output logic          halted,
  output logic          addr_err
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t      r_state;
  mem_wb_t     r_mw;
  logic        r_addr_err;
  logic        r_halted;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_rf_wdata;

  itype_t      w_type;
  logic        w_run;
  logic        w_live;
  logic        w_oor;
  logic        w_ld;
  logic        w_st;
  logic [31:0] w_a_rdata;
  logic        w_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic        w_unused;

  assign w_type = itype_t'(ex_mem_type);
  assign w_run  = (r_state == S_RUN);
  assign w_live = w_run & ex_mem_valid & ~taken_branch;
  assign w_oor  = |ex_mem_aluout[31:AW];
  assign w_ld   = w_live & (w_type == LOAD);
  assign w_st   = w_live & (w_type == STORE);
  assign w_unused = &{1'b0, ex_mem_ir[31:21],
                      ex_mem_ir[10:0]};

  mips32_dmem #(
    .WORDS (DMEM_WORDS),
    .AW    (AW)
  ) u_dmem (
    .clk       (clk1),
    .rst_n     (rst_n),
    .i_a_en    (w_ld & ~w_oor),
    .i_a_we    (w_st & ~w_oor),
    .i_a_addr  (ex_mem_aluout[AW-1:0]),
    .i_a_wdata (ex_mem_b),
    .o_a_rdata (w_a_rdata),
    .i_b_we    (dbg_we),
    .i_b_addr  (dbg_addr),
    .i_b_wdata (dbg_wdata),
    .o_b_rdata (dbg_rdata)
  );

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_mw       <= '0;
      r_addr_err <= 1'b0;
    end else if (w_run) begin
      r_mw.valid <= w_live;
      r_mw.ty    <= w_type;
      r_mw.rt    <= ex_mem_ir[20:16];
      r_mw.rd    <= ex_mem_ir[15:11];
      r_mw.alu   <= ex_mem_aluout;
      r_mw.oor   <= w_oor;
      if (w_live && is_mem(w_type) && w_oor)
        r_addr_err <= 1'b1;
    end
  end

  // LMD is the registered dmem read, zeroed for a bad address
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_mw.rd;
    w_wdata = r_mw.alu;
    unique case (1'b1)
      r_mw.ty == RR_ALU: w_we = 1'b1;
      r_mw.ty == RM_ALU: begin
        w_we    = 1'b1;
        w_waddr = r_mw.rt;
      end
      r_mw.ty == LOAD: begin
        w_we    = 1'b1;
        w_waddr = r_mw.rt;
        w_wdata = r_mw.oor ? '0 : w_a_rdata;
      end
      default: w_we = 1'b0;
    endcase
    w_we = w_we & r_mw.valid & (w_waddr != 5'd0);
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_halted   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          r_rf_we    <= w_we;
          r_rf_waddr <= w_waddr;
          r_rf_wdata <= w_wdata;
          if (r_mw.valid && r_mw.ty == HALT) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end
        end
        S_HALTED: r_rf_we <= 1'b0;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign halted   = r_halted;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_mips32_mem_wb.sv
// Bench for mips32_mem_wb: directed scenarios plus a
// randomized instruction stream against a program-order model.
module tb_mips32_mem_wb;
  import mips32_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_ir;
  logic [2:0]  ex_mem_type;
  logic [31:0] ex_mem_aluout;
  logic [31:0] ex_mem_b;
  logic        taken_branch;
  logic        dbg_we;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        halted;
  logic        addr_err;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mdl_mem [16];
  bit          mdl_err;

  always #5 clk1 = ~clk1;

  mips32_mem_wb dut (
    .clk1          (clk1),
    .rst_n         (rst_n),
    .ex_mem_valid  (ex_mem_valid),
    .ex_mem_ir     (ex_mem_ir),
    .ex_mem_type   (ex_mem_type),
    .ex_mem_aluout (ex_mem_aluout),
    .ex_mem_b      (ex_mem_b),
    .taken_branch  (taken_branch),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_rdata     (dbg_rdata),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .halted        (halted),
    .addr_err      (addr_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(
    input logic [5:0] op, input logic [4:0] rd);
    return {op, 5'd1, 5'd2, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h0010};
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    ex_mem_valid  = 1'b0;
    ex_mem_ir     = '0;
    ex_mem_type   = 3'd0;
    ex_mem_aluout = '0;
    ex_mem_b      = '0;
    taken_branch  = 1'b0;
  endtask

  task automatic drive(input logic [2:0] ty,
                       input logic [31:0] ir,
                       input logic [31:0] alu,
                       input logic [31:0] b,
                       input logic tb);
    ex_mem_valid  = 1'b1;
    ex_mem_type   = ty;
    ex_mem_ir     = ir;
    ex_mem_aluout = alu;
    ex_mem_b      = b;
    taken_branch  = tb;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mdl_err = 1'b0;
  endtask

  task automatic dbg_write(input logic [9:0] a,
                           input logic [31:0] d);
    dbg_we    = 1'b1;
    dbg_addr  = a;
    dbg_wdata = d;
    tick();
    dbg_we = 1'b0;
    if (a < 16) mdl_mem[a[3:0]] = d;
  endtask

  task automatic test_reset();
    idle();
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if (rf_we !== 1'b0)
      $display("FAIL reset_rf_we got %0b want 0", rf_we);
    else n_pass++;
    n_total++;
    if (rf_waddr !== 5'd0)
      $display("FAIL reset_waddr got %0d want 0", rf_waddr);
    else n_pass++;
    n_total++;
    if (rf_wdata !== 32'd0)
      $display("FAIL reset_wdata got %h want 0", rf_wdata);
    else n_pass++;
    n_total++;
    if (halted !== 1'b0)
      $display("FAIL reset_halted got %0b want 0", halted);
    else n_pass++;
    n_total++;
    if (addr_err !== 1'b0)
      $display("FAIL reset_addr_err got %0b want 0", addr_err);
    else n_pass++;
    n_total++;
    if (dbg_rdata !== 32'd0)
      $display("FAIL reset_dbg got %h want 0", dbg_rdata);
    else n_pass++;
    rst_n = 1'b1;
    mdl_err = 1'b0;
  endtask

  task automatic test_preload();
    for (int i = 0; i < 16; i++)
      dbg_write(10'(i), $urandom);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 10'(i);
      tick();
      n_total++;
      if (dbg_rdata !== mdl_mem[i])
        $display("FAIL preload[%0d] got %h want %h",
                 i, dbg_rdata, mdl_mem[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rr();
    drive(3'(RR_ALU), enc_r(ADD, 5'd3), 32'h14, '0, 1'b0);
    tick();
    idle();
    n_total++;
    if (rf_we !== 1'b0)
      $display("FAIL rr_early got %0b want 0", rf_we);
    else n_pass++;
    tick();
    n_total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 ||
        rf_wdata !== 32'h14)
      $display("FAIL rr_wb got we=%0b a=%0d d=%h want 1 3 14",
               rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    tick();
    n_total++;
    if (rf_we !== 1'b0)
      $display("FAIL rr_one_cycle got %0b want 0", rf_we);
    else n_pass++;
  endtask

  task automatic test_store_load();
    drive(3'(STORE), enc_i(SW, 5'd2), 32'd5,
          32'hDEAD_BEEF, 1'b0);
    tick();
    mdl_mem[5] = 32'hDEAD_BEEF;
    drive(3'(LOAD), enc_i(LW, 5'd7), 32'd5, '0, 1'b0);
    tick();
    idle();
    dbg_addr = 10'd5;
    n_total++;
    if (rf_we !== 1'b0)
      $display("FAIL st_no_wb got %0b want 0", rf_we);
    else n_pass++;
    tick();
    n_total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 ||
        rf_wdata !== 32'hDEAD_BEEF)
      $display("FAIL st_ld got we=%0b a=%0d d=%h want 1 7 deadbeef",
               rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    n_total++;
    if (dbg_rdata !== 32'hDEAD_BEEF)
      $display("FAIL st_ld_dbg got %h want deadbeef", dbg_rdata);
    else n_pass++;
  endtask

  task automatic test_branch_squash();
    dbg_write(10'd9, 32'h11);
    drive(3'(STORE), enc_i(SW, 5'd2), 32'd9,
          32'hBAD0_BAD0, 1'b1);
    tick();
    drive(3'(RR_ALU), enc_r(ADD, 5'd6), 32'h77, '0, 1'b1);
    tick();
    idle();
    dbg_addr = 10'd9;
    tick();
    n_total++;
    if (rf_we !== 1'b0)
      $display("FAIL squash_we got %0b want 0", rf_we);
    else n_pass++;
    n_total++;
    if (dbg_rdata !== 32'h11)
      $display("FAIL squash_mem got %h want 11", dbg_rdata);
    else n_pass++;
  endtask

  task automatic test_r0_oor();
    drive(3'(RM_ALU), enc_i(ADDI, 5'd0), 32'h55, '0, 1'b0);
    tick();
    idle();
    tick();
    n_total++;
    if (rf_we !== 1'b0)
      $display("FAIL r0_we got %0b want 0", rf_we);
    else n_pass++;
    drive(3'(LOAD), enc_i(LW, 5'd6), 32'h400, '0, 1'b0);
    tick();
    drive(3'(STORE), enc_i(SW, 5'd2), 32'h405,
          32'h5555_AAAA, 1'b0);
    n_total++;
    if (addr_err !== 1'b1)
      $display("FAIL oor_err got %0b want 1", addr_err);
    else n_pass++;
    tick();
    idle();
    dbg_addr = 10'd5;
    n_total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd6 ||
        rf_wdata !== 32'd0)
      $display("FAIL oor_ld got we=%0b a=%0d d=%h want 1 6 0",
               rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (addr_err !== 1'b1)
      $display("FAIL oor_sticky got %0b want 1", addr_err);
    else n_pass++;
    n_total++;
    if (dbg_rdata !== mdl_mem[5])
      $display("FAIL oor_st_drop got %h want %h",
               dbg_rdata, mdl_mem[5]);
    else n_pass++;
    do_reset();
    n_total++;
    if (addr_err !== 1'b0)
      $display("FAIL oor_clear got %0b want 0", addr_err);
    else n_pass++;
  endtask

  task automatic test_collision();
    drive(3'(STORE), enc_i(SW, 5'd2), 32'd12,
          32'hB0B0_0001, 1'b0);
    dbg_we = 1'b1; dbg_addr = 10'd12;
    dbg_wdata = 32'hA0A0_0002;
    tick();
    mdl_mem[12] = 32'hB0B0_0001;
    drive(3'(STORE), enc_i(SW, 5'd2), 32'd14,
          32'hD0D0_0004, 1'b0);
    dbg_addr = 10'd13; dbg_wdata = 32'hC0C0_0003;
    tick();
    mdl_mem[13] = 32'hC0C0_0003;
    mdl_mem[14] = 32'hD0D0_0004;
    idle();
    dbg_we = 1'b0;
    for (int a = 12; a < 15; a++) begin
      dbg_addr = 10'(a);
      tick();
      n_total++;
      if (dbg_rdata !== mdl_mem[a])
        $display("FAIL collide[%0d] got %h want %h",
                 a, dbg_rdata, mdl_mem[a]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit          q_we[$];
    logic [4:0]  q_a[$];
    logic [31:0] q_d[$];
    bit          ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] ir, alu, b;
    int          ty;
    bit          v, tb, oor;
    int          n;
    n = 300;
    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        ty  = int'($urandom_range(0, 4));
        ir  = $urandom;
        b   = $urandom;
        v   = ($urandom_range(0, 9) != 0);
        tb  = ($urandom_range(0, 9) == 0);
        oor = ($urandom_range(0, 11) == 0);
        alu = $urandom;
        if (ty == 2 || ty == 3)
          alu = oor ? (32'h400 << $urandom_range(0, 21)) |
                      32'($urandom_range(0, 15))
                    : 32'($urandom_range(0, 15));
        ew = 1'b0; ea = '0; ed = '0;
        if (v && !tb) begin
          case (ty)
            0: begin ea = ir[15:11]; ed = alu; ew = 1; end
            1: begin ea = ir[20:16]; ed = alu; ew = 1; end
            2: begin
              ea = ir[20:16]; ew = 1;
              ed = oor ? 32'd0 : mdl_mem[alu[3:0]];
              if (oor) mdl_err = 1'b1;
            end
            3: begin
              if (oor) mdl_err = 1'b1;
              else mdl_mem[alu[3:0]] = b;
            end
            default: ew = 1'b0;
          endcase
          if (ea == 5'd0) ew = 1'b0;
        end
        drive(3'(ty), ir, alu, b, tb);
        ex_mem_valid = v;
        q_we.push_back(ew);
        q_a.push_back(ea);
        q_d.push_back(ed);
      end else idle();
      tick();
      n_total++;
      if (addr_err !== mdl_err)
        $display("FAIL rnd_err[%0d] got %0b want %0b",
                 j, addr_err, mdl_err);
      else n_pass++;
      if (j >= 1) begin
        ew = q_we.pop_front();
        ea = q_a.pop_front();
        ed = q_d.pop_front();
        n_total++;
        if (rf_we !== ew ||
            (ew && (rf_waddr !== ea || rf_wdata !== ed)))
          $display("FAIL rnd_wb[%0d] got %0b/%0d/%h want %0b/%0d/%h",
                   j - 1, rf_we, rf_waddr, rf_wdata, ew, ea, ed);
        else n_pass++;
      end
    end
  endtask

  task automatic test_halt();
    drive(3'(HALT), {HLT, 26'd0}, '0, '0, 1'b0);
    tick();
    n_total++;
    if (halted !== 1'b0)
      $display("FAIL halt_early got %0b want 0", halted);
    else n_pass++;
    drive(3'(RR_ALU), enc_r(ADD, 5'd4), 32'h99, '0, 1'b0);
    tick();
    n_total++;
    if (halted !== 1'b1 || rf_we !== 1'b0)
      $display("FAIL halt_set got h=%0b we=%0b want 1 0",
               halted, rf_we);
    else n_pass++;
    drive(3'(STORE), enc_i(SW, 5'd2), 32'd3,
          32'hCAFE_F00D, 1'b0);
    tick();
    idle();
    dbg_addr = 10'd3;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rf_we !== 1'b0 || halted !== 1'b1)
        $display("FAIL halt_frozen[%0d] got we=%0b h=%0b want 0 1",
                 k, rf_we, halted);
      else n_pass++;
      tick();
    end
    n_total++;
    if (dbg_rdata !== mdl_mem[3])
      $display("FAIL halt_st_block got %h want %h",
               dbg_rdata, mdl_mem[3]);
    else n_pass++;
    dbg_write(10'd3, 32'h1234_5678);
    tick();
    n_total++;
    if (dbg_rdata !== 32'h1234_5678)
      $display("FAIL halt_dbg got %h want 12345678", dbg_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    dbg_addr = 10'd2;
    drive(3'(LOAD), enc_i(LW, 5'd8), 32'd2, '0, 1'b0);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    n_total++;
    if (rf_we !== 1'b0 || halted !== 1'b0 ||
        addr_err !== 1'b0)
      $display("FAIL rst_mid got we=%0b h=%0b e=%0b want 0 0 0",
               rf_we, halted, addr_err);
    else n_pass++;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++;
      if (rf_we !== 1'b0)
        $display("FAIL rst_mid_we[%0d] got %0b want 0", k, rf_we);
      else n_pass++;
    end
    n_total++;
    if (dbg_rdata !== mdl_mem[2])
      $display("FAIL rst_mem_kept got %h want %h",
               dbg_rdata, mdl_mem[2]);
    else n_pass++;
  endtask

  initial begin
    mdl_err = 1'b0;
    test_reset();
    test_preload();
    test_rr();
    test_store_load();
    test_branch_squash();
    test_r0_oor();
    test_collision();
    do_reset();
    test_random();
    do_reset();
    test_halt();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
